// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM encoding
// and a small index-to-one-hot helper.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/priority_encoder8to3.sv
// 8:3 priority encoder, highest set index wins; valid flags a non-zero input.
module priority_encoder8to3
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_vec,
  output logic [ID_W-1:0]    idx,
  output logic               valid
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx   = '0;
    valid = |req_vec;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_vec[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with registered one-hot grant held until release.
// Optional grant timeout enabled by defining GRANT_TIMEOUT_EN.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               timeout
);

  if (MAX_HOLD < 2 || (2 ** HOLD_W) <= MAX_HOLD) begin : g_param_check
    $error("rr_arbiter8: need MAX_HOLD >= 2 and 2**HOLD_W > MAX_HOLD");
  end

  state_t              state_reg;
  logic [ID_W-1:0]     last_id_reg;
  logic [NUM_REQ-1:0]  gnt_reg;
  logic [ID_W-1:0]     gnt_id_reg;
  logic                timeout_reg;

  logic [NUM_REQ-1:0]  below_mask;
  logic [NUM_REQ-1:0]  cand;
  logic [NUM_REQ-1:0]  masked;
  logic [ID_W-1:0]     masked_idx;
  logic [ID_W-1:0]     full_idx;
  logic                masked_valid;
  logic                full_valid;
  logic [ID_W-1:0]     win_id;
  logic                owner_req;

  // Clients strictly below the last owner get first pick.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign below_mask[gi] = (ID_W'(gi) < last_id_reg);
  end

  // The current owner never competes against itself on release.
  always_comb begin
    cand = req;
    if (state_reg == ST_GRANT) cand[gnt_id_reg] = 1'b0;
  end

  assign masked    = cand & below_mask;
  assign owner_req = req[gnt_id_reg];

  priority_encoder8to3 u_enc_masked (
    .req_vec (masked),
    .idx     (masked_idx),
    .valid   (masked_valid)
  );

  priority_encoder8to3 u_enc_full (
    .req_vec (cand),
    .idx     (full_idx),
    .valid   (full_valid)
  );

  assign win_id = masked_valid ? masked_idx : full_idx;

`ifdef GRANT_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      last_id_reg <= ID_W'(NUM_REQ - 1);
      gnt_reg     <= '0;
      gnt_id_reg  <= '0;
      timeout_reg <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
      hold_cnt_reg <= '0;
`endif
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (full_valid) begin
            state_reg   <= ST_GRANT;
            gnt_reg     <= id_to_onehot(win_id);
            gnt_id_reg  <= win_id;
            last_id_reg <= win_id;
`ifdef GRANT_TIMEOUT_EN
            hold_cnt_reg <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (owner_req) begin
`ifdef GRANT_TIMEOUT_EN
            // last_id keeps the revoked owner so it goes to the back of the line.
            if (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1)) begin
              state_reg   <= ST_IDLE;
              gnt_reg     <= '0;
              gnt_id_reg  <= '0;
              timeout_reg <= 1'b1;
            end else begin
              hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
`endif
          end else if (full_valid) begin
            gnt_reg     <= id_to_onehot(win_id);
            gnt_id_reg  <= win_id;
            last_id_reg <= win_id;
`ifdef GRANT_TIMEOUT_EN
            hold_cnt_reg <= '0;
`endif
          end else begin
            state_reg  <= ST_IDLE;
            gnt_reg    <= '0;
            gnt_id_reg <= '0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = (state_reg == ST_GRANT);
  assign gnt_id    = gnt_id_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus random traffic
// compared every cycle against a rotation-order reference model.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 16;
`ifdef GRANT_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic       timeout;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: owner index (-1 = none), last owner, hold length, timeout pulse.
  int m_owner = -1;
  int m_last  = 7;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  always @(posedge clk) begin
    int no, nl, nh, w, c;
    bit nt;
    no = m_owner; nl = m_last; nh = m_hold; nt = 1'b0;
    if (rst) begin
      no = -1; nl = 7; nh = 0;
    end else if (m_owner >= 0 && req[m_owner]) begin
      if (TIMEOUT_ON && m_hold == MAX_HOLD - 1) begin
        no = -1; nt = 1'b1;
      end else begin
        nh = m_hold + 1;
      end
    end else begin
      // Walk last-1, last-2, ... wrapping round; first requester wins.
      w = -1;
      for (int s = 1; s <= 8; s++) begin
        c = (m_last - s + 8) % 8;
        if (w < 0 && req[c] && c != m_owner) w = c;
      end
      if (w >= 0) begin
        no = w; nl = w; nh = 0;
      end else begin
        no = -1;
      end
    end
    m_owner <= no;
    m_last  <= nl;
    m_hold  <= nh;
    m_to    <= nt;
  end

  int prev_owner = -1;

  always @(negedge clk) begin
    logic [7:0] e_gnt;
    logic [2:0] e_id;
    if (chk_en) begin
      e_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
      e_id  = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
      tests++;
      if (gnt !== e_gnt || gnt_valid !== (m_owner >= 0) || gnt_id !== e_id || timeout !== m_to) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t req=%h got gnt=%h v=%b id=%0d to=%b want gnt=%h v=%b id=%0d to=%b",
                 $time, req, gnt, gnt_valid, gnt_id, timeout, e_gnt, (m_owner >= 0), e_id, m_to);
      end
      if (m_owner != prev_owner)
        $display("[TB] t=%0t req=%h owner %0d -> %0d", $time, req, prev_owner, m_owner);
      prev_owner = m_owner;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end else begin
      $display("[TB] %s = %0d ok", name, act);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    step(1);
    rst = 1'b0;
  endtask

  int rot_exp[9] = '{6, 5, 4, 3, 2, 1, 0, 7, 6};

  initial begin
    // 1: reset with all requests high
    rst = 1'b1;
    req = 8'hFF;
    step(1);
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_gnt", int'(gnt), 0);
      chk("reset_valid", int'(gnt_valid), 0);
      chk("reset_id", int'(gnt_id), 0);
      step(1);
    end
    do_reset();

    // 2: single requester
    req = 8'h10;
    step(1);
    chk("single_gnt", int'(gnt), 'h10);
    chk("single_id", int'(gnt_id), 4);
    chk("single_model", m_owner, 4);
    step(4);
    chk("single_held", int'(gnt_id), 4);
    req = 8'h00;
    step(1);
    chk("single_release", int'(gnt), 0);

    // 3: rotation with each owner dropping for one cycle
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step(1);
      chk($sformatf("rot_%0d_id", k), int'(gnt_id), rot_exp[k]);
      chk($sformatf("rot_%0d_valid", k), int'(gnt_valid), 1);
      req = 8'hFF & ~(8'h01 << rot_exp[k]);
    end

    // 4: owner 3 releases as 5 and 1 arrive
    do_reset();
    req = 8'h08;
    step(1);
    chk("simul_first", int'(gnt_id), 3);
    req = 8'h22;
    step(1);
    chk("simul_next", int'(gnt_id), 1);
    chk("simul_model", m_owner, 1);

    // boundary: only req[7] alone yields id 7 from reset
    do_reset();
    req = 8'h80;
    step(1);
    chk("only7", int'(gnt_id), 7);
    do_reset();
    req = 8'h81;
    step(1);
    chk("id7_loses", int'(gnt_id), 0);

    // 5: long hold with optional timeout
    do_reset();
    req = 8'h05;
    step(1);
`ifdef GRANT_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      chk("to_hold_id", int'(gnt_id), 2);
      step(1);
    end
    chk("to_gap_valid", int'(gnt_valid), 0);
    chk("to_pulse", int'(timeout), 1);
    step(1);
    chk("to_next_id", int'(gnt_id), 0);
    chk("to_next_valid", int'(gnt_valid), 1);
`else
    for (int i = 0; i < 100; i++) begin
      if (gnt_id != 3'd2 || timeout != 1'b0 || gnt_valid != 1'b1) chk("hold_100", int'(gnt_id), 2);
      step(1);
    end
    chk("hold_after_100", int'(gnt_id), 2);
    chk("hold_no_timeout", int'(timeout), 0);
`endif

    // 6: reset mid-grant
    do_reset();
    req = 8'h20;
    step(1);
    chk("midrst_id", int'(gnt_id), 5);
    rst = 1'b1;
    step(1);
    chk("midrst_gnt", int'(gnt), 0);
    rst = 1'b0;
    req = 8'h21;
    step(1);
    chk("midrst_regrant", int'(gnt_id), 5);
    chk("midrst_model", m_last, 5);

    // random traffic, checked by the per-cycle compare process
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) rst = 1'b1;
      else rst = 1'b0;
      if ($urandom_range(0, 15) == 0) req = 8'($urandom);
      else if ($urandom_range(0, 3) == 0) req = req ^ (8'h01 << $urandom_range(0, 7));
      step(1);
    end
    rst = 1'b0;
    req = 8'h00;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
